boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Parametrised boot/IO sequencer between the UART byte streams and the core's instruction and data memories. It sends a handshake byte, then receives a program section and a data section and packs bytes into memory words. It starts the core, then streams a result region back byte by byte. Compared with the previous generation, it adds a configurable word width, length-prefixed or idle-timeout section framing, zero-padded partial-word flush, configurable memory read latency, and a valid/ready transmit handshake.

## Interface
- `DATAW`, 32: memory word width; multiple of 8, at least 8. `NB = DATAW/8`.
- `IADDRW`, 14: instruction memory byte-address width.
- `DADDRW`, 16: data memory byte-address width.
- `RD_LAT`, 2: data memory read latency in cycles, at least 1.
- `LEN_PREFIX`, 0:
  - 1: each section is preceded by a 4-byte little-endian byte count.
  - 0: a section ends on `rx_timeout`.
- `RESULT_BASE`, 0: data memory byte address where the result region starts.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid
- `rx_data`  in  8  received byte
- `rx_timeout`  in  1  receive line idle (one-cycle pulse)
- `tx_valid`  out  1  `tx_data` is valid
- `tx_data`  out  8  byte to transmit
- `tx_ready`  in  1  transmitter accepts the byte
- `imem_we`  out  1  instruction memory write strobe
- `imem_addr`  out  IADDRW  instruction memory byte address
- `imem_wdata`  out  DATAW  instruction memory write word
- `dmem_we`  out  1  data memory write strobe
- `dmem_re`  out  1  data memory read strobe
- `dmem_addr`  out  DADDRW  data memory byte address
- `dmem_wdata`  out  DATAW  data memory write word
- `dmem_rdata`  in  DATAW  data memory read word, valid `RD_LAT` cycles after `dmem_re`
- `mem_sel`  out  1  memory owner: 0 = sequencer, 1 = core
- `core_start`  out  1  one-cycle core start pulse
- `core_done`  in  1  core finished (one-cycle pulse)
- `result_bytes`  in  32  result length in bytes; sampled when `core_done` is high

## Operation
- States: `ACK_P`, `RX_PROG`, `ACK_D`, `RX_DATA`, `RUN`, `TX_RD`, `TX_WAIT`, `TX_OUT`.
- `ACK_P`: present byte `8'h99`; on `tx_valid & tx_ready` go to `RX_PROG`.
- `ACK_D`: present byte `8'haa`; on `tx_valid & tx_ready` go to `RX_DATA`.
- `rx_valid` is ignored in every state other than `RX_PROG` and `RX_DATA`.
- Byte packing is little-endian: byte k of a word lands in bits `[8k+7:8k]`.
- When the `NB`-th byte of a word arrives, the following cycle issues `imem_we` (`RX_PROG`) or `dmem_we` (`RX_DATA`).
- The write address starts at 0 in each section and advances by `NB` after each write. It wraps modulo 2^ADDRW with no error.
- Section end:
  - `LEN_PREFIX=0`: `rx_timeout`.
  - `LEN_PREFIX=1`: the byte count reaches 0. A count of 0 ends the section directly after the prefix. `rx_timeout` is ignored.
- At section end, any partial word is zero-padded and written in one extra cycle before the state advances.
- `RX_PROG` ends into `ACK_D`. `RX_DATA` ends into `RUN`, with a one-cycle `core_start` pulse on entry.
- `RUN`: `mem_sel=1`. On `core_done`, latch `result_bytes` into `remain` and set the read address to `RESULT_BASE`.
  - If `remain` is 0, go to `ACK_P`.
  - Otherwise go to `TX_RD`.
- `TX_RD`: one-cycle `dmem_re`, then `TX_WAIT` for `RD_LAT` cycles. Capture `dmem_rdata` into a shift register and go to `TX_OUT`.
- `TX_OUT`: emit the low byte first. Each accepted byte decrements `remain` and shifts the register.
  - When `remain` reaches 0, go to `ACK_P` (the next boot).
  - When all `NB` bytes of the word are sent, advance the address by `NB` and go to `TX_RD`.
- `remain` is 32 bits; the latched value is never re-sampled.

## Timing
- Reset:
  - State = `ACK_P`.
  - All strobes and `tx_valid` = 0.
  - Addresses, counters, shift registers and `tx_data` = 0.
  - `mem_sel` = 0.
- `tx_valid` asserts 1 cycle after entry to `ACK_P`, `ACK_D` or `TX_OUT`.
- Valid/ready rule: `tx_data` is held stable while `tx_valid & ~tx_ready`.
- Write latency: a byte arriving at cycle t that completes a word gives a write strobe at t+1.
- Back-to-back `rx_valid` pulses every cycle are supported with no byte loss.
- Simultaneous `rx_valid` and `rx_timeout`: the byte is packed first, then the partial-word flush includes it.
- Mid-operation `rst` aborts immediately, from any state, to the reset values.

## Structure
- Package `boot_pkg`: the state enum and the constants `ACK_PROG=8'h99` and `ACK_DATA=8'haa`.
- Sub-module `byte_packer`, shared by both receive sections. Ports: byte in, flush, word out, word-valid.

## Test plan
- `DATAW=32`, `LEN_PREFIX=0`:
  - Stimulus: 8 program bytes `01..08`, then timeout.
  - Required: `imem` writes `32'h04030201@0`, then `32'h08070605@4`; then `8'haa` is transmitted.
- Data section of 6 bytes, then timeout.
  - Required: two `dmem_we`; the second word is `32'h0000_0605` at address 4.
- `LEN_PREFIX=1`:
  - Stimulus: prefix `05 00 00 00`, 5 bytes, then 3 extra bytes.
  - Required: 2 writes only; the extra bytes are ignored until the next section.
- `core_done` with `result_bytes=5`, `dmem` word0 = `32'hDDCCBBAA`, word1 = `32'h...EE`, `tx_ready` toggling.
  - Required: `tx_data` sequence `AA BB CC DD EE`, stable while stalled; then `8'h99`.
- `result_bytes=0`.
  - Required: no `dmem_re`; `8'h99` is re-sent.
- `rst` asserted mid-`TX_OUT`.
  - Required: next cycle `tx_valid=0`, state `ACK_P`, and addresses reset to 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared state encoding and handshake bytes for the boot sequencer.
package boot_pkg;
  typedef enum logic [2:0] {
    ACK_P, RX_PROG, ACK_D, RX_DATA, RUN, TX_RD, TX_WAIT, TX_OUT
  } boot_state_t;

  localparam logic [7:0] ACK_PROG = 8'h99;
  localparam logic [7:0] ACK_DATA = 8'haa;
endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer; a completed word or a flushed partial word
// (zero-padded) is presented on word_vld one cycle later. No backpressure.
module byte_packer #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_vld,
  input  logic [7:0]       byte_dat,
  input  logic             flush,
  output logic             word_vld,
  output logic [DATAW-1:0] word_dat
);
  localparam int NB = DATAW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATAW-1:0] acc_q, acc_d;
  logic [DATAW-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (byte_vld) begin
      acc_d[{cnt_q, 3'b000} +: 8] = byte_dat;
      cnt_d = cnt_q + 1'b1;
    end
    // The accumulator is cleared after every word, so a flush is already zero-padded.
    if (byte_vld && cnt_q == CW'(NB - 1)) begin
      vld_d  = 1'b1;
      word_d = acc_d;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (flush) begin
      if (byte_vld || cnt_q != '0) begin
        vld_d  = 1'b1;
        word_d = acc_d;
      end
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      word_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign word_vld = vld_q;
  assign word_dat = word_q;
endmodule

// File: rtl/boot_sequencer.sv
// Boot/IO sequencer: handshake, load program and data sections, run the core, stream results.
// Write strobe one cycle after the completing byte; transmit bytes held stable until tx_ready.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int          DATAW       = 32,
  parameter int          IADDRW      = 14,
  parameter int          DADDRW      = 16,
  parameter int          RD_LAT      = 2,
  parameter int          LEN_PREFIX  = 0,
  parameter int unsigned RESULT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_timeout,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [IADDRW-1:0] imem_addr,
  output logic [DATAW-1:0]  imem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  output logic [DADDRW-1:0] dmem_addr,
  output logic [DATAW-1:0]  dmem_wdata,
  input  logic [DATAW-1:0]  dmem_rdata,
  output logic              mem_sel,
  output logic              core_start,
  input  logic              core_done,
  input  logic [31:0]       result_bytes
);
  localparam int NB = DATAW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = $clog2(RD_LAT + 1);
  localparam int AW = (IADDRW > DADDRW) ? IADDRW : DADDRW;
  localparam bit LP = (LEN_PREFIX != 0);

  boot_state_t      st_q, st_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      remain_q, remain_d, len_q, len_d;
  logic [DATAW-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [2:0]       hdr_q, hdr_d;
  logic             end_q, end_d;
  logic             tx_valid_q, tx_valid_d, dmem_re_q, dmem_re_d;
  logic             mem_sel_q, mem_sel_d, core_start_q, core_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pk_in, pk_flush, pk_vld, sec_end, tx_acc;
  logic [DATAW-1:0] pk_word;

  byte_packer #(.DATAW(DATAW)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .byte_vld (pk_in),
    .byte_dat (rx_data),
    .flush    (pk_flush),
    .word_vld (pk_vld),
    .word_dat (pk_word)
  );

  always_comb begin
    st_d = st_q;  addr_d = addr_q;  remain_d = remain_q;  len_d = len_q;
    shreg_d = shreg_q;  bcnt_d = bcnt_q;  wcnt_d = wcnt_q;  hdr_d = hdr_q;
    end_d = end_q;  tx_valid_d = 1'b0;  tx_data_d = tx_data_q;
    pk_in = 1'b0;  pk_flush = 1'b0;  sec_end = 1'b0;
    tx_acc = tx_valid_q & tx_ready;
    if (pk_vld) addr_d = addr_q + AW'(NB);
    case (st_q)
      ACK_P, ACK_D: begin
        tx_data_d  = (st_q == ACK_P) ? ACK_PROG : ACK_DATA;
        tx_valid_d = ~tx_acc;
        if (tx_acc) st_d = (st_q == ACK_P) ? RX_PROG : RX_DATA;
      end
      RX_PROG, RX_DATA: begin
        if (!end_q) begin
          if (rx_valid) begin
            if (LP && hdr_q != 3'd4) begin
              len_d[{hdr_q[1:0], 3'b000} +: 8] = rx_data;
              hdr_d = hdr_q + 3'd1;
              if (hdr_q == 3'd3 && {rx_data, len_q[23:0]} == 32'd0) sec_end = 1'b1;
            end else begin
              pk_in = 1'b1;
              if (LP) begin
                len_d = len_q - 32'd1;
                if (len_q == 32'd1) sec_end = 1'b1;
              end
            end
          end
          if (!LP && rx_timeout) sec_end = 1'b1;
          pk_flush = sec_end;
          end_d    = sec_end;
        end else begin
          // Flush write lands this cycle; then restart addressing for the next section.
          end_d  = 1'b0;
          hdr_d  = '0;
          len_d  = '0;
          addr_d = '0;
          st_d   = (st_q == RX_PROG) ? ACK_D : RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          remain_d = result_bytes;
          addr_d   = AW'(RESULT_BASE);
          st_d     = (result_bytes == 32'd0) ? ACK_P : TX_RD;
        end
      end
      TX_RD: begin
        wcnt_d = WW'(1);
        st_d   = TX_WAIT;
      end
      TX_WAIT: begin
        if (wcnt_q == WW'(RD_LAT)) begin
          shreg_d = dmem_rdata;
          bcnt_d  = '0;
          st_d    = TX_OUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      TX_OUT: begin
        tx_valid_d = 1'b1;
        if (tx_acc) begin
          shreg_d  = shreg_q >> 8;
          remain_d = remain_q - 32'd1;
          bcnt_d   = bcnt_q + 1'b1;
          if (remain_d == 32'd0) begin
            st_d       = ACK_P;
            tx_valid_d = 1'b0;
          end else if (bcnt_q == CW'(NB - 1)) begin
            st_d       = TX_RD;
            tx_valid_d = 1'b0;
            addr_d     = addr_q + AW'(NB);
          end
        end
        tx_data_d = shreg_d[7:0];
      end
      default: st_d = ACK_P;
    endcase
    dmem_re_d    = (st_d == TX_RD);
    mem_sel_d    = (st_d == RUN);
    core_start_d = (st_d == RUN) && (st_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ACK_P;  addr_q <= '0;  remain_q <= '0;  len_q <= '0;
      shreg_q <= '0;  bcnt_q <= '0;  wcnt_q <= '0;  hdr_q <= '0;  end_q <= 1'b0;
      tx_valid_q <= 1'b0;  tx_data_q <= '0;  dmem_re_q <= 1'b0;
      mem_sel_q <= 1'b0;  core_start_q <= 1'b0;
    end else begin
      st_q <= st_d;  addr_q <= addr_d;  remain_q <= remain_d;  len_q <= len_d;
      shreg_q <= shreg_d;  bcnt_q <= bcnt_d;  wcnt_q <= wcnt_d;  hdr_q <= hdr_d;  end_q <= end_d;
      tx_valid_q <= tx_valid_d;  tx_data_q <= tx_data_d;  dmem_re_q <= dmem_re_d;
      mem_sel_q <= mem_sel_d;  core_start_q <= core_start_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign imem_we    = pk_vld && (st_q == RX_PROG);
  assign dmem_we    = pk_vld && (st_q == RX_DATA);
  assign imem_addr  = addr_q[IADDRW-1:0];
  assign dmem_addr  = addr_q[DADDRW-1:0];
  assign imem_wdata = pk_word;
  assign dmem_wdata = pk_word;
  assign dmem_re    = dmem_re_q;
  assign mem_sel    = mem_sel_q;
  assign core_start = core_start_q;
endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench: one sequencer with timeout framing, one with length-prefix framing.
module tb_boot_sequencer;
  import boot_pkg::*;

  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, cs_n = 0, d1_we_n = 0, rdy_mode = 1;

  // timeout-framed instance
  logic        rx_valid = 0, rx_timeout = 0, tx_valid, tx_ready, imem_we, dmem_we, dmem_re;
  logic        mem_sel, core_start, core_done = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic [13:0] imem_addr;
  logic [15:0] dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata, dmem_rdata, result_bytes = 0, rd_s1;
  // length-prefixed instance
  logic        rx_valid1 = 0, rx_timeout1 = 0, tx_valid1, tx_ready1 = 0, imem_we1, dmem_we1, dmem_re1;
  logic        mem_sel1, core_start1;
  logic [7:0]  rx_data1 = 0, tx_data1;
  logic [13:0] imem_addr1;
  logic [15:0] dmem_addr1;
  logic [31:0] imem_wdata1, dmem_wdata1;

  boot_sequencer #(.DATAW(32), .IADDRW(14), .DADDRW(16), .RD_LAT(2), .LEN_PREFIX(0), .RESULT_BASE(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_timeout(rx_timeout),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .mem_sel(mem_sel), .core_start(core_start),
    .core_done(core_done), .result_bytes(result_bytes));

  boot_sequencer #(.DATAW(32), .IADDRW(14), .DADDRW(16), .RD_LAT(2), .LEN_PREFIX(1), .RESULT_BASE(0)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_timeout(rx_timeout1),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
    .dmem_we(dmem_we1), .dmem_re(dmem_re1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
    .dmem_rdata(32'h0), .mem_sel(mem_sel1), .core_start(core_start1),
    .core_done(1'b0), .result_bytes(32'h0));

  wr_t        q_im[$], q_dm[$], q_im1[$];
  logic [7:0] q_tx[$];
  logic [31:0] q_rd[$];
  logic [31:0] dm [0:15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_wr(input string tag, input int n, input wr_t e, input logic [31:0] a,
                        input logic [31:0] d);
    chk({tag, "_pending"}, 64'(n > 0), 64'd1);
    if (n > 0) begin
      chk({tag, "_addr"}, 64'(a), 64'(e.addr));
      chk({tag, "_data"}, 64'(d), 64'(e.data));
      chk({tag, "_cyc"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  // Data memory model: reads are poisoned unless dmem_re was seen RD_LAT cycles earlier.
  always @(posedge clk) begin
    rd_s1      <= dmem_re ? dm[dmem_addr[5:2]] : 32'hDEAD_BEEF;
    dmem_rdata <= rd_s1;
  end

  logic       hold_v = 0;
  logic [7:0] hold_d = 0;
  wr_t        e0, e1, e2;
  int         n0, n1, n2;
  always @(negedge clk) begin
    if (imem_we) begin
      n0 = q_im.size(); if (n0 > 0) e0 = q_im.pop_front();
      cmp_wr("imem", n0, e0, 32'(imem_addr), imem_wdata);
    end
    if (dmem_we) begin
      n1 = q_dm.size(); if (n1 > 0) e1 = q_dm.pop_front();
      cmp_wr("dmem", n1, e1, 32'(dmem_addr), dmem_wdata);
    end
    if (imem_we1) begin
      n2 = q_im1.size(); if (n2 > 0) e2 = q_im1.pop_front();
      cmp_wr("imem1", n2, e2, 32'(imem_addr1), imem_wdata1);
    end
    if (dmem_we1) d1_we_n++;
    if (hold_v && tx_valid) chk("tx_stable", 64'(tx_data), 64'(hold_d));
    hold_v = tx_valid && !tx_ready;
    hold_d = tx_data;
    if (tx_valid && tx_ready) begin
      if (q_tx.size() == 0) chk("tx_extra", 64'(q_tx.size()), 64'd1);
      else chk("tx_byte", 64'(tx_data), 64'(q_tx.pop_front()));
    end
    if (dmem_re) begin
      if (q_rd.size() == 0) chk("rd_extra", 64'(q_rd.size()), 64'd1);
      else chk("rd_addr", 64'(dmem_addr), 64'(q_rd.pop_front()));
    end
    if (core_start) begin
      cs_n++;
      chk("cs_memsel", 64'(mem_sel), 64'd1);
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        default: tx_ready = ~tx_ready;
      endcase
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input logic to);
    rx_valid = 1'b1; rx_data = b; rx_timeout = to;
    step();
    rx_valid = 1'b0; rx_timeout = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b, input logic to);
    rx_valid1 = 1'b1; rx_data1 = b; rx_timeout1 = to;
    step();
    rx_valid1 = 1'b0; rx_timeout1 = 1'b0;
  endtask

  task automatic pulse_to();
    rx_timeout = 1'b1; step(); rx_timeout = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (q_tx.size() != 0 && n < 400) begin step(); n++; end
    chk({tag, "_drained"}, 64'(q_tx.size()), 64'd0);
  endtask

  task automatic wait_cs(input int target);
    int n = 0;
    while (cs_n < target && n < 100) begin step(); n++; end
    chk("core_start_seen", 64'(cs_n), 64'(target));
  endtask

  task automatic finish_core(input logic [31:0] nbytes);
    core_done = 1'b1; result_bytes = nbytes;
    step();
    core_done = 1'b0; result_bytes = 32'd77;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) dm[i] = 32'h0;
    dm[4] = 32'hDDCC_BBAA;
    dm[5] = 32'h1122_33EE;
    step(3);
    chk("rst_txv", 64'(tx_valid), 64'd0);
    chk("rst_txd", 64'(tx_data), 64'd0);
    chk("rst_we", 64'({imem_we, dmem_we, dmem_re, core_start}), 64'd0);
    chk("rst_memsel", 64'(mem_sel), 64'd0);
    chk("rst_iaddr", 64'(imem_addr), 64'd0);
    chk("rst_daddr", 64'(dmem_addr), 64'd0);
    chk("rst_txv1", 64'(tx_valid1), 64'd0);
    rst = 1'b0;

    // Boot 1: 8 program bytes, 6 data bytes with the last byte coinciding with the timeout.
    q_tx.push_back(ACK_PROG);
    wait_tx("ack_p0");
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) q_im.push_back('{cyc + 1, 32'd0, 32'h0403_0201});
      if (i == 8) q_im.push_back('{cyc + 1, 32'd4, 32'h0807_0605});
      send(8'(i), 1'b0);
    end
    q_tx.push_back(ACK_DATA);
    pulse_to();
    wait_tx("ack_d0");
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) q_dm.push_back('{cyc + 1, 32'd0, 32'h0403_0201});
      if (i == 6) q_dm.push_back('{cyc + 1, 32'd4, 32'h0000_0605});
      send(8'(i), i == 6);
    end
    wait_cs(1);
    chk("run_memsel", 64'(mem_sel), 64'd1);
    q_rd.push_back(32'd16);
    q_rd.push_back(32'd20);
    q_tx.push_back(8'hAA); q_tx.push_back(8'hBB); q_tx.push_back(8'hCC);
    q_tx.push_back(8'hDD); q_tx.push_back(8'hEE); q_tx.push_back(ACK_PROG);
    rdy_mode = 2;
    finish_core(32'd5);
    wait_tx("result5");
    chk("post_memsel", 64'(mem_sel), 64'd0);
    rdy_mode = 1;

    // Boot 2: empty sections, zero-length result.
    q_tx.push_back(ACK_DATA);
    pulse_to();
    wait_tx("ack_d1");
    pulse_to();
    wait_cs(2);
    q_tx.push_back(ACK_PROG);
    finish_core(32'd0);
    wait_tx("result0");

    // Length-prefixed instance: 5-byte section, ignored timeout, 3 trailing bytes, then an empty section.
    chk("d1_ack_v", 64'(tx_valid1), 64'd1);
    chk("d1_ack_p", 64'(tx_data1), 64'(ACK_PROG));
    tx_ready1 = 1'b1; step(); tx_ready1 = 1'b0;
    send1(8'h05, 1'b0); send1(8'h00, 1'b0); send1(8'h00, 1'b0); send1(8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) q_im1.push_back('{cyc + 1, 32'd0, 32'h2423_2221});
      if (i == 5) q_im1.push_back('{cyc + 1, 32'd4, 32'h0000_0025});
      send1(8'(8'h20 + i), i == 2);
    end
    send1(8'h31, 1'b0); send1(8'h32, 1'b0); send1(8'h33, 1'b0);
    step(2);
    chk("d1_ack_d_v", 64'(tx_valid1), 64'd1);
    chk("d1_ack_d", 64'(tx_data1), 64'(ACK_DATA));
    tx_ready1 = 1'b1; step(); tx_ready1 = 1'b0;
    send1(8'h00, 1'b0); send1(8'h00, 1'b0); send1(8'h00, 1'b0); send1(8'h00, 1'b0);
    step(3);
    chk("d1_run", 64'(mem_sel1), 64'd1);
    chk("d1_imem_left", 64'(q_im1.size()), 64'd0);
    chk("d1_dmem_we", 64'(d1_we_n), 64'd0);

    // Boot 3: reset while a result byte is stalled.
    q_tx.push_back(ACK_DATA);
    pulse_to();
    wait_tx("ack_d2");
    pulse_to();
    wait_cs(3);
    q_rd.push_back(32'd16);
    rdy_mode = 0;
    finish_core(32'd8);
    begin
      int n = 0;
      while (!tx_valid && n < 50) begin step(); n++; end
    end
    chk("stall_txv", 64'(tx_valid), 64'd1);
    chk("stall_txd", 64'(tx_data), 64'hAA);
    chk("stall_addr", 64'(dmem_addr), 64'd16);
    rst = 1'b1;
    step();
    chk("mid_rst_txv", 64'(tx_valid), 64'd0);
    chk("mid_rst_daddr", 64'(dmem_addr), 64'd0);
    chk("mid_rst_iaddr", 64'(imem_addr), 64'd0);
    chk("mid_rst_memsel", 64'(mem_sel), 64'd0);
    rst = 1'b0;
    q_tx.push_back(ACK_PROG);
    rdy_mode = 1;
    wait_tx("ack_p_after_rst");

    step(3);
    chk("imem_left", 64'(q_im.size()), 64'd0);
    chk("dmem_left", 64'(q_dm.size()), 64'd0);
    chk("rd_left", 64'(q_rd.size()), 64'd0);
    chk("core_start_n", 64'(cs_n), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
